lcd_seq_ctrl: RTL and testbench

//  Sequencer for the character LCD port. Queues LCD bytes from a CPU-side MMIO decoder in a small FIFO.

---
 rtl/lcd_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lcd_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_seq_ctrl
//   Character-LCD port sequencer. CPU-side MMIO writes are queued in a small
//   FIFO. Each entry is then driven onto the LCD pins with programmable setup,
//   enable-pulse, hold and settle timing.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   wr_valid_i    enqueue request
//   wr_ready_o    FIFO can accept (level != FIFO_DEPTH)
//   wr_rs_i       1 = character data, 0 = command
//   wr_data_i     byte to send
//   lcd_data_o    LCD data bus (registered)
//   lcd_ctrl_o    {RS,RW}, RW always 0 (registered)
//   lcd_enable_o  LCD E strobe (registered)
//   busy_o        transfer in progress or FIFO non-empty
//   level_o       FIFO occupancy
// ---------------------------------------------------------------------------
module lcd_seq_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned DATA_WAIT    = 40,
    parameter int unsigned CMD_WAIT     = 1600
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic                          wr_rs_i,
    input  logic [7:0]                    wr_data_i,
    output logic [7:0]                    lcd_data_o,
    output logic [1:0]                    lcd_ctrl_o,
    output logic                          lcd_enable_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_B = (DATA_WAIT > CMD_WAIT) ? DATA_WAIT : CMD_WAIT;
    localparam int unsigned MAX_C = (HOLD_CYCLES > MAX_B) ? HOLD_CYCLES : MAX_B;
    localparam int unsigned MAXP  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    // Counter only ever holds (parameter - 1).
    localparam int unsigned CW    = (MAXP <= 2) ? 1 : $clog2(MAXP);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    // Guarded by the zero-wait checks below, so the underflow case is never loaded.
    localparam logic [CW-1:0] DATA_LD  = CW'(int'(DATA_WAIT) - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(int'(CMD_WAIT) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      lcd_data_q;
    logic [1:0]      lcd_ctrl_q;
    logic            lcd_enable_q;

    // FIFO storage: {rs, data}
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            push, pop;
    logic [8:0]      head;

    // Ready comes only from the registered level, so a full FIFO refuses a
    // push even on the cycle the FSM pops.
    assign wr_ready_o = (level_q != LW'(FIFO_DEPTH));
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = (state_q == S_IDLE) && (level_q != '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {wr_rs_i, wr_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lcd_data_q   <= '0;
            lcd_ctrl_q   <= '0;
            lcd_enable_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (level_q != '0) begin
                        lcd_data_q <= head[7:0];
                        lcd_ctrl_q <= {head[8], 1'b0};
                        cnt_q      <= SETUP_LD;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        lcd_enable_q <= 1'b1;
                        cnt_q        <= PULSE_LD;
                        state_q      <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        lcd_enable_q <= 1'b0;
                        cnt_q        <= HOLD_LD;
                        state_q      <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        // Settle time depends on the RS bit of the byte just sent.
                        if (lcd_ctrl_q[1]) begin
                            if (DATA_WAIT == 0) begin
                                state_q <= S_IDLE;
                            end else begin
                                cnt_q   <= DATA_LD;
                                state_q <= S_WAIT;
                            end
                        end else begin
                            if (CMD_WAIT == 0) begin
                                state_q <= S_IDLE;
                            end else begin
                                cnt_q   <= CMD_LD;
                                state_q <= S_WAIT;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) state_q <= S_IDLE;
                    else             cnt_q   <= cnt_q - CW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lcd_data_o   = lcd_data_q;
    assign lcd_ctrl_o   = lcd_ctrl_q;
    assign lcd_enable_o = lcd_enable_q;
    assign level_o      = level_q;
    assign busy_o       = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_seq_ctrl
//   Self-checking bench for lcd_seq_ctrl (DEPTH=4, SETUP=2, PULSE=3, HOLD=1,
//   DATA_WAIT=4, CMD_WAIT=10). Cycle k is the clock period following edge
//   k-1, with the push sampled at edge 0. Every accepted byte is queued as
//   the expected {ctrl,data}. A negedge monitor pops the queue on each
//   enable rise and checks that the bus stays stable through the hold cycle.
// ---------------------------------------------------------------------------
module tb_lcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid, wr_ready, wr_rs;
    logic [7:0] wr_data, lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable, busy;
    logic [2:0] level;

    lcd_seq_ctrl #(
        .FIFO_DEPTH  (4),
        .SETUP_CYCLES(2),
        .PULSE_CYCLES(3),
        .HOLD_CYCLES (1),
        .DATA_WAIT   (4),
        .CMD_WAIT    (10)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_rs_i     (wr_rs),
        .wr_data_i   (wr_data),
        .lcd_data_o  (lcd_data),
        .lcd_ctrl_o  (lcd_ctrl),
        .lcd_enable_o(lcd_enable),
        .busy_o      (busy),
        .level_o     (level)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [9:0] sb[$];
    int         falls[$];
    int         strobes = 0;
    int         mon_cyc = 0;
    logic       en_prev = 1'b0;
    logic [9:0] cap = '0;
    logic       bad = 1'b0;
    bit         flush = 1'b0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [1:0] ctrl;
        int         en_first;
        int         en_last;
        int         idle;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic rs, input logic [7:0] d, input bit expect_accept);
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        if (expect_accept) sb.push_back({rs, 1'b0, d});
    endtask

    task automatic wait_idle(input int limit, input string name);
        int c = 0;
        while (busy && c < limit) begin
            tick(1);
            c++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_single(input vec_t v);
        int first_en = -1;
        int last_en  = -1;
        int idle_c   = -1;
        wr_valid = 1'b1;
        wr_rs    = v.rs;
        wr_data  = v.data;
        sb.push_back({v.ctrl, v.data});
        tick(1);
        wr_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) check("single_busy_c1", {31'd0, busy}, 32'd1);
            if (c == 2) begin
                check("single_data_c2", {24'd0, lcd_data}, {24'd0, v.data});
                check("single_ctrl_c2", {30'd0, lcd_ctrl}, {30'd0, v.ctrl});
            end
            if (lcd_enable) begin
                if (first_en < 0) first_en = c;
                last_en = c;
            end
            if (!busy && idle_c < 0) idle_c = c;
            tick(1);
        end
        check("single_en_first", first_en, v.en_first);
        check("single_en_last", last_en, v.en_last);
        check("single_idle_cycle", idle_c, v.idle);
    endtask

    // Scoreboard / bus-stability monitor
    always @(negedge clk) begin
        mon_cyc++;
        if (flush) begin
            sb.delete();
            en_prev = 1'b0;
            bad     = 1'b0;
            flush   = 1'b0;
        end else begin
            if (lcd_enable === 1'b1 && !en_prev) begin
                strobes++;
                cap = {lcd_ctrl, lcd_data};
                bad = 1'b0;
                check("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) check("strobe_byte", {22'd0, cap}, {22'd0, sb.pop_front()});
            end else if (lcd_enable === 1'b1 || en_prev) begin
                if ({lcd_ctrl, lcd_data} !== cap) bad = 1'b1;
                if (lcd_enable !== 1'b1) begin
                    falls.push_back(mon_cyc);
                    check("strobe_stable", {31'd0, bad}, 32'd0);
                end
            end
            en_prev = (lcd_enable === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        vecs[0] = '{rs: 1'b1, data: 8'h41, ctrl: 2'b10, en_first: 4, en_last: 6, idle: 12};
        vecs[1] = '{rs: 1'b0, data: 8'h01, ctrl: 2'b00, en_first: 4, en_last: 6, idle: 18};
        vecs[2] = '{rs: 1'b1, data: 8'hA5, ctrl: 2'b10, en_first: 4, en_last: 6, idle: 12};
        vecs[3] = '{rs: 1'b0, data: 8'h38, ctrl: 2'b00, en_first: 4, en_last: 6, idle: 18};

        rst = 1'b1; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = '0;
        tick(3);
        rst = 1'b0;
        check("reset_data", {24'd0, lcd_data}, 32'd0);
        check("reset_ctrl", {30'd0, lcd_ctrl}, 32'd0);
        check("reset_enable", {31'd0, lcd_enable}, 32'd0);
        check("reset_level", {29'd0, level}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ready", {31'd0, wr_ready}, 32'd1);

        // Single transfers: data and command timing
        for (int i = 0; i < 4; i++) run_single(vecs[i]);

        // Back-to-back data bytes
        falls.delete();
        drive(1'b1, 8'h48, 1'b1);
        tick(1);
        drive(1'b1, 8'h69, 1'b1);
        tick(1);
        wr_valid = 1'b0;
        wait_idle(100, "b2b_idle");
        check("b2b_fall_count", falls.size(), 2);
        if (falls.size() >= 2) check("b2b_fall_spacing", falls[1] - falls[0], 11);
        check("b2b_sb_empty", sb.size(), 0);

        // FIFO fill: wr_valid held for 6 cycles, 5 accepted
        s0 = strobes;
        for (int i = 0; i < 6; i++) begin
            check("fill_ready", {31'd0, wr_ready}, {31'd0, i < 5});
            drive(1'b1, 8'h30 + 8'(i), i < 5);
            tick(1);
        end
        wr_valid = 1'b0;
        check("fill_level_full", {29'd0, level}, 32'd4);
        wait_idle(200, "fill_idle");
        check("fill_level_end", {29'd0, level}, 32'd0);
        check("fill_strobes", strobes - s0, 5);
        check("fill_sb_empty", sb.size(), 0);

        // Full FIFO with a simultaneous pop: push refused
        drive(1'b0, 8'h0C, 1'b1);          // cycle 0, command with long settle
        tick(1);
        wr_valid = 1'b0;                   // cycle 1
        tick(1);
        drive(1'b1, 8'hB0, 1'b1); tick(1); // cycles 2..5
        drive(1'b1, 8'hB1, 1'b1); tick(1);
        drive(1'b1, 8'hB2, 1'b1); tick(1);
        drive(1'b1, 8'hB3, 1'b1); tick(1);
        wr_valid = 1'b0;                   // cycle 6
        tick(12);                          // cycle 18: IDLE pop cycle
        check("full_pop_level", {29'd0, level}, 32'd4);
        check("full_pop_ready", {31'd0, wr_ready}, 32'd0);
        drive(1'b1, 8'hEE, 1'b0);
        tick(1);
        wr_valid = 1'b0;
        check("full_pop_level_next", {29'd0, level}, 32'd3);
        wait_idle(300, "full_pop_idle");
        check("full_pop_sb_empty", sb.size(), 0);

        // Reset during the enable pulse with two entries still queued
        drive(1'b1, 8'h51, 1'b1); tick(1); // cycle 0
        drive(1'b1, 8'h52, 1'b1); tick(1); // cycle 1
        drive(1'b1, 8'h53, 1'b1); tick(1); // cycle 2
        wr_valid = 1'b0;
        tick(2);                           // cycle 5
        check("rst_mid_pre_enable", {31'd0, lcd_enable}, 32'd1);
        check("rst_mid_pre_level", {29'd0, level}, 32'd2);
        rst = 1'b1;
        tick(1);                           // cycle 6
        rst = 1'b0;
        flush = 1'b1;
        check("rst_mid_enable", {31'd0, lcd_enable}, 32'd0);
        check("rst_mid_level", {29'd0, level}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ready", {31'd0, wr_ready}, 32'd1);
        s0 = strobes;
        tick(60);
        check("rst_mid_no_strobes", strobes - s0, 0);
        check("rst_mid_busy_later", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
